// File: rtl/cuckoo_probe_sequencer.sv
// Cuckoo page-table lookup sequencer: walks hash ways, reads buckets, reports hit/miss.
// Optional macro HASH_PIPE_EN registers the hash before the bucket RAM address (3-cycle probe).
module cuckoo_probe_sequencer #(
    parameter int unsigned VPN_BITS  = 45,
    parameter int unsigned HASH_BITS = 32,
    parameter int unsigned IDX_BITS  = 10,
    parameter int unsigned NUM_WAYS  = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [VPN_BITS-1:0] req_vpn,
    output logic [VPN_BITS-1:0] hash_vpn,
    output logic [1:0]          hash_id,
    input  logic [HASH_BITS-1:0] hash_out,
    output logic                mem_rd_en,
    output logic [IDX_BITS-1:0] mem_rd_addr,
    input  logic [VPN_BITS:0]   mem_rd_data,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic                resp_hit,
    output logic [1:0]          resp_way,
    output logic [IDX_BITS-1:0] resp_index
);

`ifdef HASH_PIPE_EN
    typedef enum logic [2:0] {S_IDLE, S_HASH, S_HREG, S_CMP, S_RESP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_HASH, S_CMP, S_RESP} state_t;
`endif

    localparam logic [1:0] LAST_WAY = 2'(NUM_WAYS - 1);

    state_t              state_q, state_d;
    logic [VPN_BITS-1:0] vpn_q, vpn_d;
    logic [1:0]          way_q, way_d;
    logic [IDX_BITS-1:0] idx_q, idx_d;
    logic                hit_q, hit_d;
    logic [1:0]          rway_q, rway_d;
    logic [IDX_BITS-1:0] rindex_q, rindex_d;
    logic                tag_hit;
    logic                unused_hash;

`ifdef HASH_PIPE_EN
    logic [IDX_BITS-1:0] hash_q, hash_d;
`endif

    // Only the low IDX_BITS of the hash address the bucket table.
    assign unused_hash = ^hash_out;

    assign tag_hit    = mem_rd_data[VPN_BITS] && (mem_rd_data[VPN_BITS-1:0] == vpn_q);
    assign hash_vpn   = vpn_q;
    assign hash_id    = way_q;
    assign resp_valid = (state_q == S_RESP);
    assign resp_hit   = hit_q;
    assign resp_way   = rway_q;
    assign resp_index = rindex_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            vpn_q    <= '0;
            way_q    <= '0;
            idx_q    <= '0;
            hit_q    <= 1'b0;
            rway_q   <= '0;
            rindex_q <= '0;
`ifdef HASH_PIPE_EN
            hash_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            vpn_q    <= vpn_d;
            way_q    <= way_d;
            idx_q    <= idx_d;
            hit_q    <= hit_d;
            rway_q   <= rway_d;
            rindex_q <= rindex_d;
`ifdef HASH_PIPE_EN
            hash_q   <= hash_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        vpn_d       = vpn_q;
        way_d       = way_q;
        idx_d       = idx_q;
        hit_d       = hit_q;
        rway_d      = rway_q;
        rindex_d    = rindex_q;
        req_ready   = 1'b0;
        mem_rd_en   = 1'b0;
        mem_rd_addr = '0;
`ifdef HASH_PIPE_EN
        hash_d      = hash_q;
`endif
        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    vpn_d   = req_vpn;
                    way_d   = '0;
                    state_d = S_HASH;
                end
            end
            S_HASH: begin
`ifdef HASH_PIPE_EN
                hash_d      = hash_out[IDX_BITS-1:0];
                state_d     = S_HREG;
`else
                mem_rd_en   = 1'b1;
                mem_rd_addr = hash_out[IDX_BITS-1:0];
                idx_d       = hash_out[IDX_BITS-1:0];
                state_d     = S_CMP;
`endif
            end
`ifdef HASH_PIPE_EN
            S_HREG: begin
                mem_rd_en   = 1'b1;
                mem_rd_addr = hash_q;
                idx_d       = hash_q;
                state_d     = S_CMP;
            end
`endif
            S_CMP: begin
                if (tag_hit) begin
                    hit_d    = 1'b1;
                    rway_d   = way_q;
                    rindex_d = idx_q;
                    state_d  = S_RESP;
                end else if (way_q == LAST_WAY) begin
                    hit_d    = 1'b0;
                    rway_d   = '0;
                    rindex_d = idx_q;
                    state_d  = S_RESP;
                end else begin
                    way_d    = way_q + 2'd1;
                    state_d  = S_HASH;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule
